// File: rtl/aftab_step_counter.sv
// Step counter: loadable register that runs up (or down, with AFTAB_CNT_DOWN_EN defined)
// by a per-cycle step until it reaches a latched terminal value, then pulses done.
module aftab_step_counter #(
    parameter int SIZE   = 32,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              zero,
    input  logic              iniCnt,
    input  logic [SIZE-1:0]   initValue,
    input  logic [SIZE-1:0]   termValue,
    input  logic              start,
    input  logic              stop,
    input  logic [STEP_W-1:0] step,
    input  logic              down,
    output logic [SIZE-1:0]   dataOut,
    output logic              co,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [SIZE-1:0]   term_q;
    logic [STEP_W-1:0] step_eff;
    logic [SIZE:0]     step_ext;
    logic [SIZE:0]     sum;
    logic              reach;
    logic [SIZE-1:0]   next_val;

    // A zero step would stall a run forever, so it is promoted to one.
    assign step_eff = (step == '0) ? STEP_W'(1) : step;
    assign step_ext = (SIZE + 1)'(step_eff);
    assign sum      = {1'b0, dataOut} + step_ext;

`ifdef AFTAB_CNT_DOWN_EN
    logic          dir_q;
    logic [SIZE:0] diff;

    assign diff = {1'b0, dataOut} - step_ext;

    // The extra MSB is the carry (up) or borrow (down); either one clamps to term.
    always_comb begin
        if (dir_q) begin
            reach    = diff[SIZE] | (diff[SIZE-1:0] <= term_q);
            next_val = diff[SIZE-1:0];
        end else begin
            reach    = sum[SIZE] | (sum[SIZE-1:0] >= term_q);
            next_val = sum[SIZE-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dir_q <= 1'b0;
        else if (!zero && !iniCnt && start && state == IDLE)
            dir_q <= down;
    end
`else
    logic unused_down;

    assign unused_down = down;

    always_comb begin
        reach    = sum[SIZE] | (sum[SIZE-1:0] >= term_q);
        next_val = sum[SIZE-1:0];
    end
`endif

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dataOut <= '0;
            term_q  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (zero) begin
                state   <= IDLE;
                dataOut <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iniCnt) begin
                            dataOut <= initValue;
                        end else if (start) begin
                            term_q <= termValue;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state <= IDLE;
                        end else if (reach) begin
                            dataOut <= term_q;
                            state   <= DONE;
                            done    <= 1'b1;
                        end else begin
                            dataOut <= next_val;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN);
    assign co   = &dataOut;

endmodule
